store_buffer: RTL and testbench

Buffers stores between the store data-formatting stage and the data-memory write port. Each accepted store already carries zero-extended data in its low bytes. The block turns it into a word-aligned address, lane-shifted write data and a 4-bit byte enable, and queues it in a small FIFO. The FIFO drains to data memory over a valid/ack handshake, so the execute stage does not stall on memory write latency.

---
 rtl/store_buffer.sv | 137 +++++++++++++
 tb/tb_store_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: formats stores into word address, lane-shifted data and byte enables, then drains them in order.
// Optional misaligned-store trap enabled with `define STORE_BUF_MISALIGN_TRAP_EN.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [2:0]               st_func3,
  output logic                     st_err,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Byte enables for the lane(s) addressed by the low address bits.
  function automatic logic [3:0] fmt_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_SB:   be = 4'b0001 << off;
      F3_SH:   be = 4'b0011 << {off[1], 1'b0};
      F3_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Zero-extended store data moved onto the addressed lane(s); SH/SW ignore sub-size offset bits.
  function automatic logic [31:0] fmt_wdata(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_SB:   w = {24'h000000, d[7:0]} << {off, 3'b000};
      F3_SH:   w = {16'h0000, d[15:0]} << {off[1], 4'b0000};
      F3_SW:   w = d;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  function automatic logic is_valid_f3(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  logic [31:0]   addr_mem_r  [DEPTH];
  logic [31:0]   wdata_mem_r [DEPTH];
  logic [3:0]    be_mem_r    [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          err_r;

  logic accept_s;
  logic push_s;
  logic pop_s;
  logic trap_s;

  assign st_ready  = (count_r != CW'(DEPTH));
  assign mem_req   = (count_r != {CW{1'b0}});
  assign sb_empty  = (count_r == {CW{1'b0}});
  assign sb_count  = count_r;
  assign st_err    = err_r;
  assign mem_addr  = addr_mem_r[rd_ptr_r];
  assign mem_wdata = wdata_mem_r[rd_ptr_r];
  assign mem_be    = be_mem_r[rd_ptr_r];

  // Handshake decode: which accepted stores are enqueued and which are trapped.
  always_comb begin
    accept_s = st_valid && st_ready;
    pop_s    = mem_req && mem_ack;
    push_s   = 1'b0;
    trap_s   = 1'b0;
    if (accept_s && is_valid_f3(st_func3)) begin
`ifdef STORE_BUF_MISALIGN_TRAP_EN
      if (((st_func3 == F3_SH) && st_addr[0]) ||
          ((st_func3 == F3_SW) && (st_addr[1:0] != 2'b00))) begin
        trap_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
`else
      push_s = 1'b1;
`endif
    end else begin
      push_s = 1'b0;
    end
  end

  // FIFO pointers, occupancy and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      err_r    <= 1'b0;
    end else begin
      err_r <= trap_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, written at the tail on enqueue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i]  <= 32'h0000_0000;
        wdata_mem_r[i] <= 32'h0000_0000;
        be_mem_r[i]    <= 4'b0000;
      end
    end else if (push_s) begin
      addr_mem_r[wr_ptr_r]  <= {st_addr[31:2], 2'b00};
      wdata_mem_r[wr_ptr_r] <= fmt_wdata(st_func3, st_addr[1:0], st_data);
      be_mem_r[wr_ptr_r]    <= fmt_be(st_func3, st_addr[1:0]);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH = 4).
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_func3;
  logic        st_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        sb_empty;
  logic [2:0]  sb_count;

  int total = 0;
  int bad   = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_func3(st_func3),
    .st_err(st_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_addr  = a;
    st_data  = d;
    st_func3 = f;
    st_valid = 1'b1;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    logic acc;
    acc = 1'b0;
    present(a, d, f);
    for (int n = 0; n < 20 && !acc; n++) begin
      acc = st_ready;
      step();
    end
    st_valid = 1'b0;
    check_eq("push_timeout", 32'(acc), 32'd1);
  endtask

  task automatic ack_one();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] w,
                            input logic [3:0] be);
    check_eq({tag, "_req"},   32'(mem_req), 32'd1);
    check_eq({tag, "_addr"},  mem_addr, a);
    check_eq({tag, "_wdata"}, mem_wdata, w);
    check_eq({tag, "_be"},    32'(mem_be), 32'(be));
  endtask

  logic [31:0] lv_addr [6] = '{32'h0000_0103, 32'h0000_0202, 32'h0000_0101,
                               32'h0000_0102, 32'h0000_0200, 32'h0000_07FC};
  logic [31:0] lv_data [6] = '{32'h0000_00AB, 32'h0000_BEEF, 32'h0000_005A,
                               32'hFFFF_FF3C, 32'h0000_1234, 32'hDEAD_BEEF};
  logic [2:0]  lv_f3   [6] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b010};
  logic [31:0] lv_eaddr[6] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0100,
                               32'h0000_0100, 32'h0000_0200, 32'h0000_07FC};
  logic [31:0] lv_ew   [6] = '{32'hAB00_0000, 32'hBEEF_0000, 32'h0000_5A00,
                               32'h003C_0000, 32'h0000_1234, 32'hDEAD_BEEF};
  logic [3:0]  lv_ebe  [6] = '{4'b1000, 4'b1100, 4'b0010, 4'b0100, 4'b0011, 4'b1111};

  logic [2:0]  fill_cnt [5] = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};

  logic [31:0] exp_q[$];
  logic [31:0] pat;
  logic        prev_req, prev_ack, pre_ready;
  logic [31:0] prev_addr, prev_data;
  int          sent, done_n;

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_func3 = 3'b000;
    mem_ack = 1'b0;
    step(); step();
    check_eq("rst_count", 32'(sb_count), 32'd0);
    check_eq("rst_empty", 32'(sb_empty), 32'd1);
    check_eq("rst_ready", 32'(st_ready), 32'd1);
    check_eq("rst_req",   32'(mem_req),  32'd0);
    check_eq("rst_err",   32'(st_err),   32'd0);
    rst = 1'b0;
    step();

    // lane formatting
    for (int i = 0; i < 6; i++) begin
      push_one(lv_addr[i], lv_data[i], lv_f3[i]);
      check_head($sformatf("lane%0d", i), lv_eaddr[i], lv_ew[i], lv_ebe[i]);
      check_eq("lane_count", 32'(sb_count), 32'd1);
      ack_one();
      check_eq("lane_empty", 32'(sb_empty), 32'd1);
    end

    // fill and back-pressure
    for (int i = 0; i < 4; i++) begin
      present(32'h0000_1000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 3'b010);
      step();
    end
    check_eq("fill_count", 32'(sb_count), 32'd4);
    check_eq("fill_ready", 32'(st_ready), 32'd0);
    present(32'h0000_1010, 32'h1111_0004, 3'b010);
    step();
    check_eq("fill_wait_count", 32'(sb_count), 32'd4);
    check_eq("fill_wait_head", mem_addr, 32'h0000_1000);
    mem_ack = 1'b1;
    for (int j = 0; j < 5; j++) begin
      check_head($sformatf("fill%0d", j), 32'h0000_1000 + 32'(j * 4),
                 32'h1111_0000 + 32'(j), 4'b1111);
      check_eq("fill_drain_count", 32'(sb_count), 32'(fill_cnt[j]));
      pre_ready = st_ready;
      step();
      if (pre_ready && st_valid) st_valid = 1'b0;
    end
    mem_ack = 1'b0;
    check_eq("fill_done_empty", 32'(sb_empty), 32'd1);
    check_eq("fill_done_valid", 32'(st_valid), 32'd0);

    // hold stability and wrap-around with irregular acks
    pat = 32'hB3A5_6C91; prev_req = 1'b0; prev_ack = 1'b0;
    prev_addr = 32'h0; prev_data = 32'h0; sent = 0; done_n = 0;
    for (int cyc = 0; cyc < 300 && done_n < 20; cyc++) begin
      if (!st_valid && sent < 20) begin
        present(32'h0000_0400 + 32'(sent * 4), 32'hA500_0000 + 32'(sent), 3'b010);
        exp_q.push_back(32'h0000_0400 + 32'(sent * 4));
        sent++;
      end
      mem_ack = pat[cyc % 32];
      if (mem_req) begin
        if (exp_q.size() > 0) begin
          check_eq("hold_order", mem_addr, exp_q[0]);
          check_eq("hold_data", mem_wdata, 32'hA500_0000 + ((exp_q[0] - 32'h0000_0400) >> 2));
        end else begin
          check_eq("hold_spurious_req", 32'(mem_req), 32'd0);
        end
        if (prev_req && !prev_ack) begin
          check_eq("hold_stable_addr", mem_addr, prev_addr);
          check_eq("hold_stable_data", mem_wdata, prev_data);
        end
      end
      prev_req = mem_req; prev_ack = mem_ack;
      prev_addr = mem_addr; prev_data = mem_wdata; pre_ready = st_ready;
      step();
      if (prev_req && prev_ack) begin
        void'(exp_q.pop_front());
        done_n++;
      end
      if (st_valid && pre_ready) st_valid = 1'b0;
    end
    mem_ack = 1'b0; st_valid = 1'b0;
    check_eq("hold_retired", 32'(done_n), 32'd20);
    check_eq("hold_count", 32'(sb_count), 32'd0);
    check_eq("hold_empty", 32'(sb_empty), 32'd1);

    // simultaneous enqueue and dequeue at count 2
    push_one(32'h0000_2000, 32'h2222_0000, 3'b010);
    push_one(32'h0000_2004, 32'h2222_0001, 3'b010);
    check_eq("sim_pre_count", 32'(sb_count), 32'd2);
    present(32'h0000_2008, 32'h2222_0002, 3'b010);
    mem_ack = 1'b1;
    step();
    st_valid = 1'b0; mem_ack = 1'b0;
    check_eq("sim_count", 32'(sb_count), 32'd2);
    check_eq("sim_head", mem_addr, 32'h0000_2004);
    ack_one();
    check_head("sim_tail", 32'h0000_2008, 32'h2222_0002, 4'b1111);
    ack_one();
    check_eq("sim_empty", 32'(sb_empty), 32'd1);

    // misaligned SW
    push_one(32'h0000_0101, 32'hCAFE_F00D, 3'b010);
`ifdef STORE_BUF_MISALIGN_TRAP_EN
    check_eq("mis_err", 32'(st_err), 32'd1);
    check_eq("mis_req", 32'(mem_req), 32'd0);
    check_eq("mis_count", 32'(sb_count), 32'd0);
    step();
    check_eq("mis_err_pulse", 32'(st_err), 32'd0);
`else
    check_eq("mis_err", 32'(st_err), 32'd0);
    check_head("mis", 32'h0000_0100, 32'hCAFE_F00D, 4'b1111);
    ack_one();
    check_eq("mis_empty", 32'(sb_empty), 32'd1);
`endif

    // invalid func3 is consumed without an entry
    push_one(32'h0000_3000, 32'h3333_3333, 3'b010);
    push_one(32'h0000_3104, 32'h4444_4444, 3'b111);
    check_eq("inv_count", 32'(sb_count), 32'd1);
    check_eq("inv_err", 32'(st_err), 32'd0);
    check_head("inv_head", 32'h0000_3000, 32'h3333_3333, 4'b1111);
    ack_one();
    check_eq("inv_empty", 32'(sb_empty), 32'd1);

    // asynchronous reset with entries queued
    for (int i = 0; i < 3; i++) push_one(32'h0000_5000 + 32'(i * 4), 32'h5555_0000, 3'b010);
    check_eq("rst3_pre_count", 32'(sb_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("rst3_req",   32'(mem_req),  32'd0);
    check_eq("rst3_count", 32'(sb_count), 32'd0);
    check_eq("rst3_ready", 32'(st_ready), 32'd1);
    check_eq("rst3_empty", 32'(sb_empty), 32'd1);
    step();
    rst = 1'b0;
    step();
    check_eq("rst3_after_req", 32'(mem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
